// File: rtl/div_16bit_seq.sv
// Sequential restoring divider: one quotient bit per clock, 16 iterations per division.
// Division by zero completes immediately with an all-ones quotient and the dividend as remainder.
module div_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] pr_r, pr_s;
  logic [WIDTH-1:0] dvd_r, dvd_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] quot_r, quot_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             dbz_r, dbz_s;
  logic             accept_s;
  logic [WIDTH:0]   shifted_s;
  logic             no_borrow_s;
  logic [WIDTH-1:0] diff_s;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor
  always_comb begin
    shifted_s   = {pr_r, dvd_r[WIDTH-1]};
    no_borrow_s = (shifted_s >= {1'b0, div_r});
    // Only the low bits matter: when there is no borrow the difference is below the divisor
    diff_s      = shifted_s[WIDTH-1:0] - div_r;
  end

  // Next-state and next register values
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pr_s     = pr_r;
    dvd_s    = dvd_r;
    div_s    = div_r;
    q_s      = q_r;
    quot_s   = quot_r;
    rem_s    = rem_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    dbz_s    = dbz_r;
    accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          div_s = B;
          dvd_s = A;
          if (B == {WIDTH{1'b0}}) begin
            state_s = ST_DONE;
            quot_s  = {WIDTH{1'b1}};
            rem_s   = A;
            dbz_s   = 1'b1;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
            cnt_s   = {CNT_W{1'b0}};
            pr_s    = {WIDTH{1'b0}};
            q_s     = {WIDTH{1'b0}};
            dbz_s   = 1'b0;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy_s = 1'b1;
        pr_s   = no_borrow_s ? diff_s : shifted_s[WIDTH-1:0];
        q_s    = {q_r[WIDTH-2:0], no_borrow_s};
        dvd_s  = {dvd_r[WIDTH-2:0], 1'b0};
        cnt_s  = cnt_r + CNT_ONE;
        if (cnt_r == LAST_CNT) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          quot_s  = q_s;
          rem_s   = pr_s;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      pr_r    <= {WIDTH{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      div_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      quot_r  <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pr_r    <= pr_s;
      dvd_r   <= dvd_s;
      div_r   <= div_s;
      q_r     <= q_s;
      quot_r  <= quot_s;
      rem_r   <= rem_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dbz_r   <= dbz_s;
    end
  end

  assign quotient    = quot_r;
  assign remainder   = rem_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule
